// File: rtl/mem_block_fetch.sv
// mem_block_fetch
//   Read-side client for the block memory (mem_mod). Given a base address and
//   an element count, it walks memory in BLOCK_SIZE-word blocks through the
//   memory's combinational block-read port and streams each block downstream
//   over a valid/ready handshake, tagged with the number of valid words.
//
// Ports
//   i_clk, i_rst            clock (posedge) and synchronous active-high reset
//   i_start                 start request, only honoured while idle
//   i_base_addr, i_len      first word address and number of words to fetch
//   o_busy                  high from the start edge until the done cycle ends
//   o_done                  one-cycle pulse closing every accepted start
//   o_addr_r                registered read address to mem_mod
//   i_mem_data              block read from mem_mod, mem[a] in the MSB slot
//   o_data, o_count, o_last block payload, valid-word count, final-block flag
//   o_valid, i_ready        downstream handshake
module mem_block_fetch #(
  parameter int SIZE       = 32,
  parameter int BLOCK_SIZE = 5,
  parameter int ADDR_SIZE  = 24,
  parameter int LEN_W      = 16,
  localparam int CNT_W     = $clog2(BLOCK_SIZE + 1),
  localparam int DW        = SIZE * BLOCK_SIZE
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [ADDR_SIZE-1:0] i_base_addr,
  input  logic [LEN_W-1:0]     i_len,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [ADDR_SIZE-1:0] o_addr_r,
  input  logic [DW-1:0]        i_mem_data,
  output logic [DW-1:0]        o_data,
  output logic [CNT_W-1:0]     o_count,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_last
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    OUT   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_SIZE-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]     rem_q, rem_d;
  logic [ADDR_SIZE-1:0] addr_r_d;
  logic [DW-1:0]        data_d;
  logic [CNT_W-1:0]     count_d;
  logic                 last_d;
  logic                 valid_d;

  // Words carried by the current block: min(rem, BLOCK_SIZE). rem only
  // changes on an accepted block, so this stays stable through FETCH and OUT.
  logic [LEN_W-1:0]     blk_n;
  logic                 blk_is_last;
  logic [ADDR_SIZE-1:0] next_addr;

  assign blk_is_last = (rem_q <= LEN_W'(BLOCK_SIZE));
  assign blk_n       = blk_is_last ? rem_q : LEN_W'(BLOCK_SIZE);
  // Modulo 2^ADDR_SIZE: the carry out of the top bit is simply dropped.
  assign next_addr   = cur_addr_q + ADDR_SIZE'(blk_n);

  // Slot i (0 = MSB side) survives only if i < n; the tail slots beyond the
  // requested length are forced to zero so the consumer never sees stale words.
  function automatic logic [DW-1:0] mask_tail(input logic [DW-1:0] d,
                                              input logic [LEN_W-1:0] n);
    logic [DW-1:0] r;
    r = d;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      if (i >= int'(n)) r[DW-1-i*SIZE -: SIZE] = '0;
    end
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    rem_d      = rem_q;
    addr_r_d   = o_addr_r;
    data_d     = o_data;
    count_d    = o_count;
    last_d     = o_last;
    valid_d    = o_valid;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          if (i_len != '0) begin
            cur_addr_d = i_base_addr;
            rem_d      = i_len;
            addr_r_d   = i_base_addr;
            state_d    = FETCH;
          end else begin
            state_d = DONE;
          end
        end
      end
      FETCH: begin
        data_d  = mask_tail(i_mem_data, blk_n);
        count_d = CNT_W'(blk_n);
        last_d  = blk_is_last;
        valid_d = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        if (o_valid && i_ready) begin
          valid_d = 1'b0;
          if (o_last) begin
            state_d = DONE;
          end else begin
            cur_addr_d = next_addr;
            rem_d      = rem_q - blk_n;
            addr_r_d   = next_addr;
            state_d    = FETCH;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Register stage: all state and outputs update together on posedge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      rem_q      <= '0;
      o_addr_r   <= '0;
      o_data     <= '0;
      o_count    <= '0;
      o_last     <= 1'b0;
      o_valid    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      rem_q      <= rem_d;
      o_addr_r   <= addr_r_d;
      o_data     <= data_d;
      o_count    <= count_d;
      o_last     <= last_d;
      o_valid    <= valid_d;
    end
  end

  assign o_busy = (state_q != IDLE);
  assign o_done = (state_q == DONE);

endmodule
